// File: rtl/mc_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Groups the signals between the multicycle main controller and the datapath.
//   Op, Funct  : instruction fields from the IR (datapath -> controller)
//   Zero       : ALU zero flag (datapath -> controller)
//   PCWrite, IRWrite, RegWrite, MemWrite : datapath write enables
//   ALUSrcA, ALUSrcB, ALUOp, EXTOp, RegDst, WDSel, NPCOp : mux selects / ALU op
//   Illegal    : one-cycle pulse on an unsupported instruction
// Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface mc_ctrl_fsm_if #(
   parameter int ALUOP_W = 3
);
   logic [5:0]         Op;
   logic [5:0]         Funct;
   logic               Zero;
   logic               PCWrite;
   logic               IRWrite;
   logic               RegWrite;
   logic               MemWrite;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [ALUOP_W-1:0] ALUOp;
   logic               EXTOp;
   logic [1:0]         RegDst;
   logic [1:0]         WDSel;
   logic [1:0]         NPCOp;
   logic               Illegal;

   modport master (
      input  Op, Funct, Zero,
      output PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ALUOp,
             EXTOp, RegDst, WDSel, NPCOp, Illegal
   );

   modport slave (
      output Op, Funct, Zero,
      input  PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ALUOp,
             EXTOp, RegDst, WDSel, NPCOp, Illegal
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle MIPS main controller. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB states and drives datapath enables, mux selects and
// the 3-bit ALU operation code. Samples ALU Zero only in BRANCH.
// Ports:
//   clk  : system clock, rising edge
//   rstn : synchronous active-low reset (also masks every write enable and
//          Illegal while low)
//   bus  : mc_ctrl_fsm_if.master (Op/Funct/Zero in, control outputs out)
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
   parameter int ALUOP_W = 3
) (
   input  logic          clk,
   input  logic          rstn,
   mc_ctrl_fsm_if.master bus
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC_R = 4'd6,
      EXEC_I = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9,
      JUMP   = 4'd10
   } state_t;

   // ALU operation encoding
   localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(7);

   // Opcodes
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   // R-type function codes
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;

   function automatic logic [ALUOP_W-1:0] rtype_aluop(input logic [5:0] fn);
      case (fn)
         F_ADD:   rtype_aluop = ALU_ADD;
         F_SUB:   rtype_aluop = ALU_SUB;
         F_AND:   rtype_aluop = ALU_AND;
         F_OR:    rtype_aluop = ALU_OR;
         F_SLT:   rtype_aluop = ALU_SLT;
         F_SLTU:  rtype_aluop = ALU_SLTU;
         F_NOR:   rtype_aluop = ALU_NOR;
         default: rtype_aluop = ALU_NOP;
      endcase
   endfunction

   function automatic logic [ALUOP_W-1:0] itype_aluop(input logic [5:0] op);
      case (op)
         OP_ADDI: itype_aluop = ALU_ADD;
         OP_SLTI: itype_aluop = ALU_SLT;
         OP_ANDI: itype_aluop = ALU_AND;
         OP_ORI:  itype_aluop = ALU_OR;
         default: itype_aluop = ALU_NOP;
      endcase
   endfunction

   state_t state;
   state_t state_nxt;

   logic is_r, is_ralu, is_jr, is_ialu, is_mem, is_br, is_jmp;

   // Raw (unmasked) decode of the current state
   logic               pcwrite_raw, irwrite_raw, regwrite_raw, memwrite_raw;
   logic               illegal_raw;
   logic               alusrca;
   logic [1:0]         alusrcb;
   logic [ALUOP_W-1:0] aluop;
   logic               extop;
   logic [1:0]         regdst, wdsel, npcop;

   // Instruction class decode from the IR fields
   always_comb begin
      is_r    = (bus.Op == OP_R);
      is_ralu = is_r && (bus.Funct inside {F_ADD, F_SUB, F_AND, F_OR,
                                           F_SLT, F_SLTU, F_NOR});
      is_jr   = is_r && (bus.Funct == F_JR);
      is_ialu = bus.Op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
      is_mem  = (bus.Op == OP_LW) || (bus.Op == OP_SW);
      is_br   = (bus.Op == OP_BEQ) || (bus.Op == OP_BNE);
      is_jmp  = (bus.Op == OP_J) || (bus.Op == OP_JAL) || is_jr;
   end

   // Next state and state-driven outputs
   always_comb begin
      state_nxt    = FETCH;
      pcwrite_raw  = 1'b0;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      memwrite_raw = 1'b0;
      illegal_raw  = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      aluop        = ALU_NOP;
      extop        = 1'b0;
      regdst       = 2'b00;
      wdsel        = 2'b00;
      npcop        = 2'b00;

      case (state)
         FETCH: begin
            irwrite_raw = 1'b1;
            pcwrite_raw = 1'b1;
            state_nxt   = DECODE;
         end

         DECODE: begin
            // Branch target (PC + simm<<2) is precomputed into ALUOut here
            alusrcb = 2'b11;
            aluop   = ALU_ADD;
            extop   = 1'b1;
            if (is_mem)       state_nxt = MEMADR;
            else if (is_ralu) state_nxt = EXEC_R;
            else if (is_ialu) state_nxt = EXEC_I;
            else if (is_br)   state_nxt = BRANCH;
            else if (is_jmp)  state_nxt = JUMP;
            else begin
               state_nxt   = FETCH;
               illegal_raw = 1'b1;
            end
         end

         MEMADR: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            extop     = 1'b1;
            aluop     = ALU_ADD;
            state_nxt = (bus.Op == OP_LW) ? MEMRD : MEMWR;
         end

         MEMRD: state_nxt = MEMWB;

         MEMWB: begin
            regwrite_raw = 1'b1;
            regdst       = 2'b00;
            wdsel        = 2'b01;
            state_nxt    = FETCH;
         end

         MEMWR: begin
            memwrite_raw = 1'b1;
            state_nxt    = FETCH;
         end

         EXEC_R: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b00;
            aluop     = rtype_aluop(bus.Funct);
            state_nxt = ALUWB;
         end

         EXEC_I: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            aluop     = itype_aluop(bus.Op);
            // Logical immediates are zero-extended, arithmetic ones sign-extended
            extop     = (bus.Op == OP_ADDI) || (bus.Op == OP_SLTI);
            state_nxt = ALUWB;
         end

         ALUWB: begin
            regwrite_raw = 1'b1;
            wdsel        = 2'b00;
            regdst       = is_r ? 2'b01 : 2'b00;
            state_nxt    = FETCH;
         end

         BRANCH: begin
            alusrca     = 1'b1;
            alusrcb     = 2'b00;
            aluop       = ALU_SUB;
            npcop       = 2'b01;
            // Zero comes straight from the ALU comparing A and B this cycle
            pcwrite_raw = (bus.Op == OP_BEQ) ? bus.Zero : ~bus.Zero;
            state_nxt   = FETCH;
         end

         JUMP: begin
            pcwrite_raw = 1'b1;
            npcop       = is_jr ? 2'b11 : 2'b10;
            if (bus.Op == OP_JAL) begin
               // PC already holds PC+4 from FETCH, so it is the link value
               regwrite_raw = 1'b1;
               regdst       = 2'b10;
               wdsel        = 2'b10;
            end
            state_nxt = FETCH;
         end

         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= FETCH;
      else       state <= state_nxt;
   end

   // Write enables and Illegal are masked combinationally so that an
   // instruction interrupted by reset can never leave a partial write.
   always_comb begin
      bus.PCWrite  = rstn & pcwrite_raw;
      bus.IRWrite  = rstn & irwrite_raw;
      bus.RegWrite = rstn & regwrite_raw;
      bus.MemWrite = rstn & memwrite_raw;
      bus.Illegal  = rstn & illegal_raw;
      bus.ALUSrcA  = alusrca;
      bus.ALUSrcB  = alusrcb;
      bus.ALUOp    = aluop;
      bus.EXTOp    = extop;
      bus.RegDst   = regdst;
      bus.WDSel    = wdsel;
      bus.NPCOp    = npcop;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle main controller: the producer side of the ALUOp/Zero interface that feeds the ALU.
- Sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives datapath enables, mux selects and the 3-bit ALU operation code.
- Samples ALU Zero for conditional branches; sits between the IR/opcode fields and the multicycle datapath.

Parameters:
- ALUOP_W, 3, width of ALUOp output; fixed encoding below.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- Op  in  6  instr[31:26] from IR.
- Funct  in  6  instr[5:0] from IR.
- Zero  in  1  ALU zero flag, valid combinationally in BRANCH.
- PCWrite  out  1  PC register load enable.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- ALUSrcA  out  1  0=PC, 1=A reg.
- ALUSrcB  out  2  00=B reg, 01=const 4, 10=ext imm, 11=ext imm<<2.
- ALUOp  out  3  000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT, 110 SLTU, 111 NOR.
- EXTOp  out  1  1=sign-extend, 0=zero-extend imm16.
- RegDst  out  2  00=rt, 01=rd, 10=$31.
- WDSel  out  2  00=ALUOut, 01=MDR, 10=PC (link).
- NPCOp  out  2  00=PC+4, 01=branch target, 10=jump target, 11=jr (A reg).
- Illegal  out  1  one-cycle pulse in DECODE on an unsupported Op/Funct.

Behaviour:
- Supported instructions:
  - R-type Op=000000: add 100000, sub 100010, and 100100, or 100101, slt 101010, sltu 101011, nor 100111, jr 001000.
  - I-type: addi 001000, andi 001100, ori 001101, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101.
  - J-type: j 000010, jal 000011.
- States, 4-bit registered: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP.
- Outputs are combinational from state (plus Op/Funct/Zero where noted). Any output not listed for a state is 0 / 00 / NOP.
- FETCH: IRWrite=1, PCWrite=1, NPCOp=00. Next: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, EXTOp=1 (precomputes branch target into ALUOut). Next state by instruction:
  - lw/sw → MEMADR
  - R-ALU → EXEC_R
  - I-ALU → EXEC_I
  - beq/bne → BRANCH
  - j/jal/jr → JUMP
  - anything else → FETCH with Illegal=1; no write enable asserted.
- MEMADR: ALUSrcA=1, ALUSrcB=10, EXTOp=1, ALUOp=ADD. lw → MEMRD; sw → MEMWR.
- MEMRD: no enables → MEMWB.
- MEMWB: RegWrite=1, RegDst=00, WDSel=01 → FETCH.
- MEMWR: MemWrite=1 → FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp from Funct (add ADD, sub SUB, and AND, or OR, slt SLT, sltu SLTU, nor NOR) → ALUWB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10.
  - addi: ADD, EXTOp=1. slti: SLT, EXTOp=1.
  - andi: AND, EXTOp=0. ori: OR, EXTOp=0.
  - → ALUWB.
- ALUWB: RegWrite=1, WDSel=00, RegDst=01 if Op=000000 else 00 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, NPCOp=01, PCWrite = beq ? Zero : ~Zero → FETCH.
- JUMP:
  - PCWrite=1.
  - NPCOp = 11 for jr, 10 for j/jal.
  - jal: RegWrite=1, RegDst=10, WDSel=10 (PC already holds PC+4).
  - → FETCH.
- CPI: lw 5; sw, R-type, I-ALU 4; beq/bne 3; j/jal/jr 3; illegal 2.
- Reset:
  - rstn=0 sampled on a rising edge forces state=FETCH.
  - While rstn=0, every write enable (PCWrite, IRWrite, RegWrite, MemWrite) is forced 0, as is Illegal.
  - Mid-instruction reset aborts the instruction with no partial writes. The first cycle after release is FETCH.
- Undefined state encodings → next state FETCH, all enables 0.
- Zero is ignored in every state except BRANCH.

Test Plan:
- Reset: hold rstn=0 for 3 cycles during MEMWR of an sw → MemWrite=0 throughout; after release state=FETCH, PCWrite=IRWrite=1 in that cycle.
- R-type add (Op=0, Funct=100000) → 4 cycles; EXEC_R ALUOp=001; ALUWB RegWrite=1, RegDst=01, WDSel=00. Repeat with nor (100111) → ALUOp=111.
- lw (Op=100011) → 5 cycles; MEMADR ALUOp=001, ALUSrcB=10, EXTOp=1; MEMWB RegWrite=1, WDSel=01, RegDst=00.
- beq, Zero=1 → BRANCH ALUOp=010, PCWrite=1, NPCOp=01. Same with Zero=0 → PCWrite=0. bne with Zero=0 → PCWrite=1.
- ori (Op=001101) → EXEC_I EXTOp=0, ALUOp=100. jal (Op=000011) → JUMP PCWrite=1, NPCOp=10, RegWrite=1, RegDst=10, WDSel=10.
- Illegal Op=111111 → Illegal=1 for one cycle in DECODE, no enables asserted, next state FETCH. R-type Funct=000000 gives the same response.
